// File: rtl/uart_cmd_arbiter_pkg.sv
// Shared definitions for the UART command transmit path:
// default widths, channel indices and a clog2 helper.
package uart_cmd_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'h00;

    localparam int CH_GAME_STATE = 0;
    localparam int CH_TARGET     = 1;
    localparam int CH_OPERATE    = 2;
    localparam int CH_SCRIPT     = 3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_arbiter_fifo.sv
// Single-clock per-channel command FIFO with synchronous reset.
// A push into a full FIFO is accepted only when a pop frees a slot.
module cmd_fifo
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic wrEn;
    logic rdEn;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign rdEn  = pop && !empty;
    assign wrEn  = push && (!full || rdEn);
    assign dout  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (wrEn) wrPtr <= wrPtr + AW'(1);
            if (rdEn) rdPtr <= rdPtr + AW'(1);
            unique case ({wrEn, rdEn})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Round-robin arbiter feeding the UART transmit byte port from
// per-source command FIFOs; each byte is held until tx_ready.
module uart_cmd_arbiter
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(DEFAULT_IDLE_BYTE),
    parameter bit REPEAT_LAST = 1'b0,
    localparam int CH_W = clog2(NUM_CH),
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_full,
    output logic [NUM_CH-1:0]        ch_overflow,
    input  logic                     tx_ready,
    output logic [DATA_W-1:0]        tx_bits,
    output logic [CH_W-1:0]          tx_ch,
    output logic                     tx_is_idle
);

    logic [DATA_W-1:0] headData [NUM_CH];
    logic [CNT_W-1:0]  chCount [NUM_CH];
    logic [NUM_CH-1:0] chEmpty;
    logic [NUM_CH-1:0] chEligible;
    logic [NUM_CH-1:0] popCh;
    logic [NUM_CH-1:0] dropCh;
    logic [CH_W-1:0]   rrPtr;
    logic [CH_W-1:0]   grantIdx;
    logic [CH_W-1:0]   cand;
    logic [DATA_W-1:0] lastData;
    logic              found;
    logic              txFire;
    int                idx;

    assign txFire = tx_ready && !reset;

    for (genvar i = 0; i < NUM_CH; i++) begin : gFifo
        assign chEligible[i] = (chCount[i] != '0);
        assign popCh[i] = txFire && found && (grantIdx == CH_W'(i)) && !chEmpty[i];
        assign dropCh[i] = ch_valid[i] && ch_full[i] && !popCh[i];

        cmd_fifo #(
            .DATA_W(DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) uFifo (
            .clk  (clk),
            .reset(reset),
            .push (ch_valid[i]),
            .pop  (popCh[i]),
            .din  (ch_data[i*DATA_W +: DATA_W]),
            .dout (headData[i]),
            .count(chCount[i]),
            .full (ch_full[i]),
            .empty(chEmpty[i])
        );
    end

    // First non-empty channel after the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        grantIdx = '0;
        cand = '0;
        idx = 0;
        for (int off = 1; off <= NUM_CH; off++) begin
            idx = (int'(rrPtr) + off) % NUM_CH;
            cand = CH_W'(idx);
            if (!found && chEligible[cand]) begin
                found = 1'b1;
                grantIdx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_bits     <= IDLE_BYTE;
            tx_ch       <= '0;
            tx_is_idle  <= 1'b1;
            rrPtr       <= CH_W'(NUM_CH - 1);
            lastData    <= IDLE_BYTE;
            ch_overflow <= '0;
        end else begin
            ch_overflow <= ch_overflow | dropCh;
            if (tx_ready) begin
                if (found) begin
                    tx_bits    <= headData[grantIdx];
                    tx_ch      <= grantIdx;
                    tx_is_idle <= 1'b0;
                    lastData   <= headData[grantIdx];
                    rrPtr      <= grantIdx;
                end else begin
                    tx_bits    <= REPEAT_LAST ? lastData : IDLE_BYTE;
                    tx_is_idle <= 1'b1;
                end
            end
        end
    end

endmodule
